// File: rtl/life_pkg.sv
// Shared constants and FSM state type for the Game-of-Life grid streamer.
package life_pkg;
    localparam int GRID_W    = 16;
    localparam int GRID_H    = 16;
    localparam int CELLS     = 256;
    localparam int ROW_IDX_W = 4;
    localparam int POP_W     = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/life_row_popcount.sv
// Combinational popcount of one 16-cell grid row.
module life_row_popcount
    import life_pkg::*;
(
    input  logic [GRID_W-1:0] bits,
    output logic [4:0]        count
);
    // Sum the live cells of the row
    always_comb begin
        count = '0;
        for (int i = 0; i < GRID_W; i++) begin
            count = count + 5'(bits[i]);
        end
    end
endmodule

// File: rtl/life_grid_streamer.sv
// Captures a 16x16 Game-of-Life grid on request and streams it out one row
// per accepted handshake, then reports the live-cell total of the snapshot.
// Optional feature macro: LIFE_STREAM_POPCNT_EN (popcount accumulation and
// pop_count/pop_valid). Without it those outputs are tied low while the
// FSM timing, including the one-cycle DONE state, is unchanged.
module life_grid_streamer
    import life_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CELLS-1:0]     grid,
    input  logic                 snap,
    output logic                 busy,
    output logic                 row_valid,
    input  logic                 out_ready,
    output logic [GRID_W-1:0]    row_data,
    output logic [ROW_IDX_W-1:0] row_idx,
    output logic                 row_last,
    output logic [POP_W-1:0]     pop_count,
    output logic                 pop_valid
);
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(GRID_H - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CELLS-1:0]       snapshot;
    logic [ROW_IDX_W-1:0]   idx;
    logic                   start;
    logic                   accept;

    assign start  = (state == IDLE) && snap;
    assign accept = (state == STREAM) && out_ready;

    assign busy      = (state != IDLE);
    assign row_valid = (state == STREAM);
    assign row_data  = row_valid ? snapshot[{idx, 4'b0000} +: GRID_W] : '0;
    assign row_idx   = idx;
    assign row_last  = row_valid && (idx == LAST_ROW);

    // State register; reset wins over any pending snap
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: snap only honoured in IDLE, so snaps while busy are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snap) state_nxt = STREAM;
            STREAM:  if (out_ready && idx == LAST_ROW) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot capture and row pointer; snapshot is frozen until the next start
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= '0;
            idx      <= '0;
        end else if (start) begin
            snapshot <= grid;
            idx      <= '0;
        end else if (accept && idx != LAST_ROW) begin
            idx <= idx + 1'b1;
        end else if (state == DONE) begin
            idx <= '0;
        end
    end

`ifdef LIFE_STREAM_POPCNT_EN
    logic [4:0]       row_pop;
    logic [POP_W-1:0] acc;
    logic [POP_W-1:0] acc_nxt;
    logic [POP_W-1:0] pop_reg;

    life_row_popcount u_row_popcount (
        .bits  (row_data),
        .count (row_pop)
    );

    assign acc_nxt = acc + POP_W'(row_pop);

    // Running total; the final sum is latched on the last-row handshake so it
    // is already on pop_count during DONE and holds until the next DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            pop_reg <= '0;
        end else if (start) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_nxt;
            if (idx == LAST_ROW) pop_reg <= acc_nxt;
        end
    end

    assign pop_count = pop_reg;
    assign pop_valid = (state == DONE);
`else
    assign pop_count = '0;
    assign pop_valid = 1'b0;
`endif
endmodule

// File: tb/tb_life_grid_streamer.sv
// Scoreboard bench for life_grid_streamer: the stimulus pushes expected rows
// and totals, a negedge monitor pops and compares on each handshake/pulse.
module tb_life_grid_streamer;
`ifdef LIFE_STREAM_POPCNT_EN
    localparam bit POP_EN = 1'b1;
`else
    localparam bit POP_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [3:0]  idx;
        logic        last;
    } row_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] grid = '0;
    logic         snap = 1'b0;
    logic         busy;
    logic         row_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  row_data;
    logic [3:0]   row_idx;
    logic         row_last;
    logic [8:0]   pop_count;
    logic         pop_valid;

    int checks = 0;
    int errors = 0;

    row_t        row_q[$];
    logic [8:0]  pop_q[$];

    life_grid_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .grid      (grid),
        .snap      (snap),
        .busy      (busy),
        .row_valid (row_valid),
        .out_ready (out_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .pop_count (pop_count),
        .pop_valid (pop_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare rows on handshake, hold-stability under backpressure,
    // and totals on pop_valid
    always @(negedge clk) begin
        if (!reset) begin
            if (row_valid) begin
                if (row_q.size() == 0) begin
                    chk("unexpected_row", {12'h0, row_idx, row_data}, 32'hffff_ffff);
                end else if (out_ready) begin
                    row_t e;
                    e = row_q.pop_front();
                    chk("row_data", 32'(row_data), 32'(e.data));
                    chk("row_idx", 32'(row_idx), 32'(e.idx));
                    chk("row_last", 32'(row_last), 32'(e.last));
                end else begin
                    chk("stall_data", 32'(row_data), 32'(row_q[0].data));
                    chk("stall_idx", 32'(row_idx), 32'(row_q[0].idx));
                end
            end else begin
                chk("row_last_idle", 32'(row_last), 32'd0);
            end
            if (pop_valid) begin
                if (pop_q.size() == 0) chk("unexpected_pop", 32'(pop_count), 32'hffff_ffff);
                else chk("pop_count", 32'(pop_count), 32'(pop_q.pop_front()));
            end
        end
    end

    // Run one snapshot from an IDLE cycle (called at #1 after an edge).
    // stall_n: cycles of out_ready low on row 4; chg_at/snap_at/rst_at: cycle
    // offsets (n = 0 is T+1) to set grid to all-ones, pulse snap, assert reset.
    task automatic run(input logic [255:0] g, input int stall_n, input int chg_at,
                       input int snap_at, input int rst_at);
        int n;
        int stall_left;
        int pc;
        bit aborted;
        pc = $countones(g);
        for (int r = 0; r < 16; r++) begin
            row_t e;
            e.data = g[16*r +: 16];
            e.idx  = 4'(r);
            e.last = (r == 15);
            row_q.push_back(e);
        end
        if (POP_EN) pop_q.push_back(9'(pc));
        grid = g;
        snap = 1'b1;
        @(posedge clk); #1;
        snap = 1'b0;
        n = 0;
        stall_left = stall_n;
        aborted = 0;
        chk("first_row_valid", {31'd0, row_valid}, 32'd1);
        chk("first_row_idx", 32'(row_idx), 32'd0);
        while (busy && n < 200) begin
            if (n == chg_at) grid = '1;
            snap = (n == snap_at);
            if (row_valid && row_idx == 4'd4 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (n == 16 + stall_n) begin
                chk("done_row_valid", 32'(row_valid), 32'd0);
                chk("done_pop_valid", 32'(pop_valid), 32'(POP_EN));
                chk("done_pop_count", 32'(pop_count), POP_EN ? 32'(pc) : 32'd0);
            end
            if (n == rst_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_row_valid", 32'(row_valid), 32'd0);
                chk("rst_pop_count", 32'(pop_count), 32'd0);
                chk("rst_rows_left", 32'(row_q.size()), 32'd9);
                row_q.delete();
                pop_q.delete();
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        snap = 1'b0;
        out_ready = 1'b1;
        if (!aborted) chk("busy_cycles", 32'(n), 32'(17 + stall_n));
    endtask

    initial begin
        logic [255:0] glider;
        logic [255:0] ones;
        glider = '0;
        glider[1] = 1'b1; glider[16+2] = 1'b1;
        glider[32+0] = 1'b1; glider[32+1] = 1'b1; glider[32+2] = 1'b1;
        ones = '1;

        // Reset state, with snap asserted to show reset wins
        snap = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        snap = 1'b0;
        chk("rst0_busy", 32'(busy), 32'd0);
        chk("rst0_row_valid", 32'(row_valid), 32'd0);
        chk("rst0_row_last", 32'(row_last), 32'd0);
        chk("rst0_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst0_row_idx", 32'(row_idx), 32'd0);
        chk("rst0_row_data", 32'(row_data), 32'd0);
        chk("rst0_pop_count", 32'(pop_count), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        run(glider, 0, -1, -1, -1);
        run(ones, 0, -1, -1, -1);
        run('0, 0, -1, -1, -1);
        run(glider, 3, -1, -1, -1);
        // grid change at T+5 and ignored snap at T+8, then back-to-back restart
        run(glider, 0, 4, 7, -1);
        run(ones, 0, -1, -1, -1);
        // Abort at row 7, then a fresh stream
        run(glider, 0, -1, -1, 7);
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_pop_valid", 32'(pop_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        run(glider, 0, -1, -1, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("rows_drained", 32'(row_q.size()), 32'd0);
        chk("pops_drained", 32'(pop_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
